// File: rtl/load_store_unit.sv
// MIPS byte/half/word load-store unit for a word-wide, no-byte-enable memory.
// Optional UNALIGNED_LR_EN adds LWL/LWR merge with the captured rt value.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rt_old,
  output logic              resp_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
`ifdef UNALIGNED_LR_EN
  localparam logic [5:0] LWL = 6'h22;
  localparam logic [5:0] LWR = 6'h26;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, RESP
  } state_t;

  state_t            state;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sd_q;
  logic [DATA_W-1:0] wr_q;
`ifdef UNALIGNED_LR_EN
  logic [DATA_W-1:0] rt_q;
`else
  logic              unused_rt;
  assign unused_rt = ^rt_old;
`endif

  logic is_ld, mis, ld_ok, sw_ok, rmw_ok;

  always_comb begin
    is_ld = opcode inside {LB, LBU, LH, LHU, LW};
`ifdef UNALIGNED_LR_EN
    is_ld = is_ld || opcode == LWL || opcode == LWR;
`endif
    mis = (opcode inside {LH, LHU, SH} && addr[0])
       || (opcode inside {LW, SW} && addr[1:0] != 2'b00);
    ld_ok  = is_ld && !mis;
    sw_ok  = opcode == SW && !mis;
    rmw_ok = (opcode == SB || opcode == SH) && !mis;
  end

  // Big-endian lanes: byte k sits 8*(3-k) bits up, half h 16*(1-h) up.
  logic [1:0]        k;
  logic [4:0]        bsh, hsh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ld_v, merged;

  assign k      = addr_q[1:0];
  assign bsh    = {~k, 3'b000};
  assign hsh    = {~addr_q[1], 4'b0000};
  assign byte_v = 8'(mem_read_data >> bsh);
  assign half_v = 16'(mem_read_data >> hsh);

  always_comb begin
    ld_v = mem_read_data;
    case (op_q)
      LB:  ld_v = {{24{byte_v[7]}}, byte_v};
      LBU: ld_v = {24'b0, byte_v};
      LH:  ld_v = {{16{half_v[15]}}, half_v};
      LHU: ld_v = {16'b0, half_v};
`ifdef UNALIGNED_LR_EN
      LWL: ld_v = (mem_read_data << {k, 3'b000})
                | (rt_q & ~(32'hFFFF_FFFF << {k, 3'b000}));
      LWR: ld_v = (mem_read_data >> bsh)
                | (rt_q & ~(32'hFFFF_FFFF >> bsh));
`endif
      default: ld_v = mem_read_data;
    endcase
  end

  always_comb begin
    if (op_q == SB)
      merged = (mem_read_data & ~(32'h0000_00FF << bsh))
             | ({24'b0, sd_q[7:0]} << bsh);
    else
      merged = (mem_read_data & ~(32'h0000_FFFF << hsh))
             | ({16'b0, sd_q[15:0]} << hsh);
  end

  logic acc;
  assign acc = state == LOAD || state == RMW_RD || state == WRITE;

  assign req_ready      = state == IDLE;
  assign resp_valid     = state == RESP;
  assign mem_read       = state == LOAD || state == RMW_RD;
  assign mem_write      = state == WRITE;
  assign mem_address    = acc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_write_data = mem_write ? wr_q : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      sd_q       <= '0;
      wr_q       <= '0;
      load_data  <= '0;
      addr_error <= 1'b0;
`ifdef UNALIGNED_LR_EN
      rt_q       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          op_q       <= opcode;
          addr_q     <= addr;
          sd_q       <= store_data;
          wr_q       <= store_data;
          addr_error <= mis;
`ifdef UNALIGNED_LR_EN
          rt_q       <= rt_old;
`endif
          unique case (1'b1)
            mis:     state <= RESP;
            ld_ok:   state <= LOAD;
            sw_ok:   state <= WRITE;
            rmw_ok:  state <= RMW_RD;
            default: begin
              state     <= RESP;
              load_data <= '0;
            end
          endcase
        end
        LOAD: begin
          load_data <= ld_v;
          state     <= RESP;
        end
        RMW_RD: begin
          wr_q  <= merged;
          state <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute/memory stage and the word-wide data memory.
- Turns MIPS load/store opcodes into word accesses on a memory that has a combinational read, a single-cycle word write and no byte enables.
- Does read-modify-write for SB/SH, byte/halfword extraction with sign/zero extension for loads, and alignment checking.
- Byte order is big-endian: byte offset 0 is bits [31:24].

Parameters:
- ADDR_W, 32, width of byte address.
- DATA_W, 32, data word width; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready at a clk edge.
- opcode  in  6  MIPS primary opcode; captured on accept.
- addr  in  32  byte address; captured on accept.
- store_data  in  32  rt value for stores; captured on accept.
- rt_old  in  32  current rt value for LWL/LWR merge; captured on accept.
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  32  load result, valid with resp_valid; held until next response.
- addr_error  out  1  misaligned-access flag, valid with resp_valid.
- mem_address  out  32  word address to memory, {addr[31:2],2'b00}.
- mem_write_data  out  32  word to write.
- mem_write  out  1  memory write enable; write occurs at clk edge.
- mem_read  out  1  memory read enable.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- Reset (async, any time): state=IDLE; resp_valid=0, load_data=0, addr_error=0.
- Reset also clears mem_write=0, mem_read=0, mem_address=0, mem_write_data=0.
- Reset mid-operation abandons the access; an unissued RMW write never reaches memory.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- mem_* outputs decode combinationally from state and captured registers; they are all 0 in IDLE and RESP.
- IDLE: req_ready=1. On accept, decode the captured opcode:
  - LB 0x20, LBU 0x24, LH 0x21, LHU 0x25, LW 0x23 -> LOAD.
  - SW 0x2B -> WRITE.
  - SB 0x28, SH 0x29 -> RMW_RD.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP, addr_error=1, no memory access.
  - Any other opcode -> RESP, addr_error=0, load_data=0, no access.
- LOAD (1 cycle): mem_read=1. At the edge, extract and register load_data, then go to RESP.
  - LB/LBU: byte addr[1:0], sign-/zero-extended.
  - LH/LHU: half addr[1] (0 -> [31:16]), sign-/zero-extended.
  - LW: full word.
- RMW_RD (1 cycle): mem_read=1. At the edge, register the merged word: read word with store_data[7:0] or [15:0] replacing the addressed lane. Go to WRITE.
- WRITE (1 cycle): mem_write=1 with mem_write_data = merged word (SB/SH) or store_data (SW). Memory updates at the edge; go to RESP.
- RESP (1 cycle): resp_valid=1, req_ready=0, then IDLE.
- Latency from accept edge to resp_valid:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Errors and unsupported opcodes: 1 cycle.
- Throughput: one outstanding request. req_valid while busy is ignored; the requester holds it.
- mem_read and mem_write are never both 1.
- Stores leave load_data unchanged; addr_error is cleared on every non-error response.

Optional Feature:
- Macro: UNALIGNED_LR_EN.
- Defined: LWL 0x22 and LWR 0x26 go to LOAD, never raise addr_error, and merge with captured rt_old. With k=addr[1:0]:
  - LWL: result = (word << 8k) | (rt_old & ((1<<8k)-1)).
  - LWR: result = (word >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k))).
- Undefined: 0x22/0x26 are unsupported opcodes: 1-cycle response, load_data=0, no memory access.

Test Plan:
- Mem word@0x10=0x8899AABB; LW addr 0x10 -> mem_read high 1 cycle at 0x10; resp_valid 2 cycles after accept; load_data=0x8899AABB, addr_error=0.
- Same word; LB addr 0x11 -> load_data=0xFFFFFF99. LBU addr 0x11 -> 0x00000099. LHU addr 0x12 -> 0x0000AABB.
- Mem@0x20=0x11223344; SB addr 0x22 store_data=0x000000EE -> one RMW_RD read, one write of 0x1122EE44; resp_valid 3 cycles after accept.
- LH addr 0x13 -> resp_valid next cycle, addr_error=1, mem_read=mem_write=0 throughout.
- SH addr 0x20 accepted, reset_n pulled low during RMW_RD -> no mem_write ever; all outputs 0; req_ready=1 after release; memory still 0x11223344.
- With UNALIGNED_LR_EN, mem@0x30=0x01020304, rt_old=0xAABBCCDD:
  - LWL addr 0x31 -> 0x020304DD.
  - LWR addr 0x31 -> 0xAABB0102.
- Without UNALIGNED_LR_EN, the same LWL -> load_data=0 after 1 cycle, no memory access.
